// File: rtl/exec_pkg.sv
// Shared constants for the multi-cycle execute unit: ALU opcodes, FSM states
// and the layout of the pass-through control bundle.
package exec_pkg;
  localparam int CTRL_W = 7;

  localparam int CTRL_PCTOREG  = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_LOADSIGN = 2;
  localparam int CTRL_DSIZE    = 0;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/exec_mul_iter.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module exec_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             active;

  assign done    = active & (cnt == CNT_W'(WIDTH));
  assign product = acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= opA;
      mplier <= opB;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active & !done) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU plus optional iterative multiplier
// (enabled by EXEC_UNIT_MUL_EN), feeding one registered output stage.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    nextPC_in,
  input  logic [WIDTH-1:0]    opA_in,
  input  logic [WIDTH-1:0]    opB_in,
  input  logic [WIDTH-1:0]    imm_in,
  input  logic [3:0]          ALUCtrl_in,
  input  logic                mul_in,
  input  logic                jump_in,
  input  logic                branch_in,
  input  logic                branchZero_in,
  input  logic                RegToPC_in,
  input  logic [REG_BITS-1:0] destReg_in,
  input  logic [CTRL_W-1:0]   ctrl_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    aluResult_out,
  output logic [WIDTH-1:0]    leapAddr_out,
  output logic [WIDTH-1:0]    nextPC_out,
  output logic                leap_out,
  output logic [REG_BITS-1:0] destReg_out,
  output logic [CTRL_W-1:0]   ctrl_out,
  output logic                busy
);
  localparam int SH_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0]    alu;
    logic [WIDTH-1:0]    leapAddr;
    logic [WIDTH-1:0]    nextPC;
    logic                leap;
    logic [REG_BITS-1:0] destReg;
    logic [CTRL_W-1:0]   ctrl;
  } resp_t;

  function automatic logic [WIDTH-1:0] aluOp(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      ALU_ADD:  aluOp = a + b;
      ALU_SUB:  aluOp = a - b;
      ALU_AND:  aluOp = a & b;
      ALU_OR:   aluOp = a | b;
      ALU_XOR:  aluOp = a ^ b;
      ALU_SLL:  aluOp = a << sh;
      ALU_SRL:  aluOp = a >> sh;
      ALU_SRA:  aluOp = $signed(a) >>> sh;
      ALU_SLT:  aluOp = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: aluOp = {{(WIDTH-1){1'b0}}, a < b};
      default:  aluOp = '0;
    endcase
  endfunction

  resp_t      aluResp, nextResp, outReg;
  logic       outFree, accept, loadEn;

  assign outFree = !out_valid | out_ready;
  assign accept  = in_valid & in_ready;

  always_comb begin
    aluResp          = '0;
    aluResp.alu      = aluOp(ALUCtrl_in, opA_in, opB_in);
    aluResp.leapAddr = RegToPC_in ? opA_in : nextPC_in + imm_in;
    aluResp.nextPC   = nextPC_in;
    aluResp.leap     = jump_in | (branch_in & (branchZero_in ? (opA_in == '0) : (opA_in != '0)));
    aluResp.destReg  = destReg_in;
    aluResp.ctrl     = ctrl_in;
  end

`ifdef EXEC_UNIT_MUL_EN
  state_t              state;
  logic                mulStart, mulDone, mulLoad;
  logic [WIDTH-1:0]    product;
  logic [WIDTH-1:0]    sideLeapAddr, sideNextPC;
  logic [REG_BITS-1:0] sideDest;
  logic [CTRL_W-1:0]   sideCtrl;

  assign in_ready = (state == IDLE) & outFree;
  assign busy     = (state != IDLE);
  assign mulStart = accept & mul_in;
  assign mulLoad  = (((state == MUL) & mulDone) | (state == DONE)) & outFree;
  assign loadEn   = mulLoad | (accept & !mul_in);

  exec_mul_iter #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .reset   (reset),
    .start   (mulStart),
    .opA     (opA_in),
    .opB     (opB_in),
    .done    (mulDone),
    .product (product)
  );

  // Side-band is latched at accept since the upstream moves on during MUL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sideLeapAddr <= '0;
      sideNextPC   <= '0;
      sideDest     <= '0;
      sideCtrl     <= '0;
    end else begin
      case (state)
        IDLE: if (mulStart) begin
          state        <= MUL;
          sideLeapAddr <= aluResp.leapAddr;
          sideNextPC   <= aluResp.nextPC;
          sideDest     <= aluResp.destReg;
          sideCtrl     <= aluResp.ctrl;
        end
        MUL:     if (mulDone) state <= outFree ? IDLE : DONE;
        DONE:    if (outFree) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    nextResp = aluResp;
    if (mulLoad) begin
      nextResp.alu      = product;
      nextResp.leapAddr = sideLeapAddr;
      nextResp.nextPC   = sideNextPC;
      nextResp.leap     = 1'b0;
      nextResp.destReg  = sideDest;
      nextResp.ctrl     = sideCtrl;
    end
  end
`else
  logic unusedMul;

  assign unusedMul = mul_in;
  assign in_ready  = outFree;
  assign busy      = 1'b0;
  assign loadEn    = accept;
  assign nextResp  = aluResp;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outReg    <= '0;
      out_valid <= 1'b0;
    end else if (loadEn) begin
      outReg    <= nextResp;
      out_valid <= 1'b1;
    end else if (outFree) begin
      out_valid <= 1'b0;
    end
  end

  assign aluResult_out = outReg.alu;
  assign leapAddr_out  = outReg.leapAddr;
  assign nextPC_out    = outReg.nextPC;
  assign leap_out      = outReg.leap;
  assign destReg_out   = outReg.destReg;
  assign ctrl_out      = outReg.ctrl;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomized bench for exec_unit_mc with a transaction-level reference model;
// honours EXEC_UNIT_MUL_EN the same way as the design.
module tb_exec_unit_mc;
  localparam int W = 32;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  nextPC_in, opA_in, opB_in, imm_in;
  logic [3:0]    ALUCtrl_in;
  logic          mul_in, jump_in, branch_in, branchZero_in, RegToPC_in;
  logic [4:0]    destReg_in, destReg_out;
  logic [6:0]    ctrl_in, ctrl_out;
  logic [W-1:0]  aluResult_out, leapAddr_out, nextPC_out;
  logic          leap_out, busy;

  exec_unit_mc #(.WIDTH(W), .REG_BITS(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .nextPC_in(nextPC_in), .opA_in(opA_in), .opB_in(opB_in), .imm_in(imm_in),
    .ALUCtrl_in(ALUCtrl_in), .mul_in(mul_in), .jump_in(jump_in), .branch_in(branch_in),
    .branchZero_in(branchZero_in), .RegToPC_in(RegToPC_in), .destReg_in(destReg_in),
    .ctrl_in(ctrl_in), .out_valid(out_valid), .out_ready(out_ready),
    .aluResult_out(aluResult_out), .leapAddr_out(leapAddr_out), .nextPC_out(nextPC_out),
    .leap_out(leap_out), .destReg_out(destReg_out), .ctrl_out(ctrl_out), .busy(busy)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] refAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    sh = int'(b % W);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return W'($signed(a) >>> sh);
      4'd8: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd9: return (a < b) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Reference: one output slot plus at most one multiply in flight.
  logic          mOv, mulPend, mLeap;
  logic [W-1:0]  mAlu, mLa, mNpc, pAlu, pLa, pNpc;
  logic [4:0]    mDr, pDr;
  logic [6:0]    mCtrl, pCtrl;
  int            edgeCnt, readyEdge;

  always @(posedge clk or negedge reset) begin : model
    logic free, acc, lp;
    logic [W-1:0] la;
    if (!reset) begin
      mOv = 0; mulPend = 0; mLeap = 0; mAlu = 0; mLa = 0; mNpc = 0; mDr = 0; mCtrl = 0;
      edgeCnt = 0; readyEdge = 0;
    end else begin
      edgeCnt++;
      free = !mOv || out_ready;
      acc  = in_valid && !mulPend && free;
      la   = RegToPC_in ? opA_in : nextPC_in + imm_in;
      lp   = jump_in || (branch_in && (branchZero_in ? (opA_in == 0) : (opA_in != 0)));
      if (mulPend && edgeCnt >= readyEdge && free) begin
        mOv = 1; mAlu = pAlu; mLa = pLa; mNpc = pNpc; mLeap = 0; mDr = pDr; mCtrl = pCtrl;
        mulPend = 0;
      end else if (acc && MULEN && mul_in) begin
        mulPend = 1; readyEdge = edgeCnt + W + 1;
        pAlu = opA_in * opB_in; pLa = la; pNpc = nextPC_in; pDr = destReg_in; pCtrl = ctrl_in;
        mOv = 0;
      end else if (acc) begin
        mOv = 1; mAlu = refAlu(ALUCtrl_in, opA_in, opB_in); mLa = la; mNpc = nextPC_in;
        mLeap = lp; mDr = destReg_in; mCtrl = ctrl_in;
      end else if (free) begin
        mOv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("in_ready", in_ready, !mulPend && (!mOv || out_ready));
      chk("out_valid", out_valid, mOv);
      chk("busy", busy, MULEN && mulPend);
      if (mOv) begin
        chk("aluResult", aluResult_out, mAlu);
        chk("leapAddr", leapAddr_out, mLa);
        chk("nextPC", nextPC_out, mNpc);
        chk("leap", leap_out, mLeap);
        chk("destReg", destReg_out, mDr);
        chk("ctrl", ctrl_out, mCtrl);
      end
    end else begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", {aluResult_out, leapAddr_out}, 0);
      chk("rst_misc", {nextPC_out, leap_out, destReg_out, ctrl_out}, 0);
    end
  end

  logic randRdy = 1'b0, fixRdy = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = randRdy ? ($urandom_range(0, 3) != 0) : fixRdy;
  end

  task automatic randFields();
    nextPC_in = $urandom; opA_in = $urandom; opB_in = $urandom; imm_in = $urandom;
    ALUCtrl_in = 4'($urandom_range(0, 15)); mul_in = ($urandom_range(0, 3) == 0);
    jump_in = $urandom_range(0, 1); branch_in = $urandom_range(0, 1);
    branchZero_in = $urandom_range(0, 1); RegToPC_in = $urandom_range(0, 1);
    destReg_in = 5'($urandom); ctrl_in = 7'($urandom);
    if ($urandom_range(0, 3) == 0) opA_in = 0;
  endtask

  task automatic plain(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    ALUCtrl_in = op; opA_in = a; opB_in = b; mul_in = m;
    jump_in = 0; branch_in = 0; branchZero_in = 0; RegToPC_in = 0;
  endtask

  // Returns right after the accepting edge.
  task automatic send();
    int n;
    @(posedge clk); #1;
    in_valid = 1; n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold, prevExp;
    int n;
    in_valid = 0;
    randFields();
    plain(4'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1;

    plain(4'd0, 32'h7FFF_FFFF, 32'h1, 0);
    send();
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_result", aluResult_out, 32'h8000_0000);
    chk("add_leap", leap_out, 0);

    plain(4'd0, 0, 0, 0);
    branch_in = 1; branchZero_in = 1; nextPC_in = 32'h100; imm_in = 32'hFFFF_FFF0;
    send();
    @(negedge clk);
    chk("beq_leap", leap_out, 1);
    chk("beq_addr", leapAddr_out, 32'h0000_00F0);
    opA_in = 5;
    send();
    @(negedge clk);
    chk("beq_notaken", leap_out, 0);

    plain(4'd0, 32'h1234_5678, 32'h10, 1);
    send();
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!out_valid) chk("mul_in_ready", in_ready, 0);
    end while (!out_valid && n < 60);
    chk("mul_latency", n, MULEN ? 33 : 1);
    chk("mul_result", aluResult_out, MULEN ? 32'h2345_6780 : 32'h1234_5688);
    chk("mul_leap", leap_out, 0);

    fixRdy = 0;
    plain(4'd1, 32'd10, 32'd3, 0);
    send();
    @(negedge clk);
    hold = aluResult_out;
    chk("stall_result", hold, 32'd7);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", aluResult_out, hold);
      chk("stall_in_ready", in_ready, 0);
    end
    fixRdy = 1;

    plain(4'd0, 32'hDEAD_BEEF, 32'h3, 1);
    send();
    repeat (9) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    @(posedge clk); #2 reset = 1;
    plain(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    send();
    @(negedge clk);
    chk("after_rst", aluResult_out, 32'hF000_F000);

    prevExp = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_ready", in_ready, 1);
        chk("b2b_result", aluResult_out, prevExp);
      end
      plain(4'(i % 2), 32'(i * 1000), 32'(i * 7 + 1), 0);
      prevExp = (i % 2 == 0) ? 32'(i * 1000 + i * 7 + 1) : 32'(i * 1000 - (i * 7 + 1));
      in_valid = 1;
    end
    @(posedge clk); #1;
    in_valid = 0;
    chk("b2b_last", aluResult_out, prevExp);

    randRdy = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      randFields();
      in_valid = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    randRdy = 0;
    repeat (50) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/exec_unit_mc.md
EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of operands, PC, immediate and results (min 8, power of 2).
REQ-002 Parameter REG_BITS, default 5: width of destination register index.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port in_valid / in_ready  in / out  1 / 1  upstream handshake; transfer when both high at a clk edge.
REQ-006 Ports nextPC_in, opA_in, opB_in, imm_in  in  WIDTH each  PC+4, operands, immediate already sign-extended to WIDTH.
REQ-007 Port ALUCtrl_in  in  4  ALU op; mul_in, jump_in, branch_in, branchZero_in, RegToPC_in  in  1 each.
REQ-008 Ports destReg_in  in  REG_BITS; ctrl_in  in  7  {PCtoReg, RegWrite, MemToReg, MemWrite, loadSign, DSize[1:0]} passed through.
REQ-009 Port out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-010 Ports aluResult_out, leapAddr_out, nextPC_out  out  WIDTH; leap_out  out  1; destReg_out  out  REG_BITS; ctrl_out  out  7; busy  out  1 (FSM not IDLE).

Function
REQ-011 ALU encodings: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU; 10-15 yield 0; shift amount = opB low log2(WIDTH) bits; results modulo 2^WIDTH.
REQ-012 leap_out = jump_in | (branch_in & (branchZero_in ? opA_in==0 : opA_in!=0)).
REQ-013 leapAddr_out = RegToPC_in ? opA_in : nextPC_in + imm_in (mod 2^WIDTH, carry discarded).
REQ-014 All outputs are registered in a single output stage; out_valid stays high and outputs stay stable until out_ready is sampled high.
REQ-015 in_ready = (state==IDLE) & (!out_valid | out_ready), combinational.
REQ-016 Non-mul op: accepted at edge N, out_valid high after edge N (latency 1); simultaneous drain and accept replaces the output stage without a bubble.
REQ-017 FSM states IDLE, MUL, DONE; IDLE->MUL on accept with mul_in=1; MUL runs exactly WIDTH cycles (shift-add, one multiplier bit per cycle) with operands/side-band captured at accept.
REQ-018 MUL->IDLE loading output stage when count reaches WIDTH and output stage free (!out_valid | out_ready); else MUL->DONE, DONE->IDLE loading output when the stage frees.
REQ-019 Mul result = low WIDTH bits of opA*opB (unsigned, equal to signed low half); leap_out forced 0, leapAddr_out = computed per REQ-013 on captured operands.
REQ-020 in_ready is low throughout MUL and DONE; in_valid ignored then.

Reset
REQ-021 While reset low: state IDLE, mul counter 0, out_valid 0, all data outputs 0, busy 0; an in-flight multiply is discarded.
REQ-022 First accept possible at the first clk edge after reset deasserts.

Configuration
REQ-023 Macro EXEC_UNIT_MUL_EN: defined -> iterative multiplier and MUL/DONE states present per REQ-017..019.
REQ-024 Undefined -> no multiplier logic, mul_in ignored, such ops complete as ALU ops at latency 1, busy tied 0.

Structure
REQ-025 Package exec_pkg holds ALU op constants, FSM state enum, CTRL_W=7 and ctrl bundle field offsets.
REQ-026 One sub-module exec_mul_iter (start, operands, done, product) isolates the shift-add multiplier.

Verification
REQ-027 ADD opA=0x7FFFFFFF, opB=1, out_ready=1 -> next cycle out_valid=1, aluResult=0x80000000, leap=0.
REQ-028 branch_in=1, branchZero_in=1, opA=0, nextPC=0x100, imm=0xFFFFFFF0 -> leap=1, leapAddr=0x000000F0; opA=5 -> leap=0.
REQ-029 mul opA=0x12345678, opB=0x10 -> out_valid after exactly 33 edges from accept, aluResult=0x23456780; in_ready low meanwhile.
REQ-030 out_ready=0 for 5 cycles while out_valid -> outputs unchanged, in_ready=0; mul completing then goes DONE and loads when out_ready rises.
REQ-031 reset low mid-multiply (cycle 10) -> out_valid=0, busy=0 immediately; next op after release completes normally.
REQ-032 Back-to-back ADD/SUB with out_ready=1 -> one result per cycle, no bubbles; build without EXEC_UNIT_MUL_EN -> mul op returns ALU result at latency 1.
